alu_seq: RTL

Parametrised sequential ALU for the microprocessor datapath. It registers its result and a four-bit status flag set, takes operands through a valid/ready handshake, and supports carry-chained arithmetic, shifts and rotates, compare, and a multi-cycle shift-add multiply. It sits between the register file and the accumulator write-back path, replacing the 8-bit combinational ALU. Operation codes 0001–0110 keep their existing meaning.

---
 rtl/alu_seq.sv | 97 +++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, carry-chained arithmetic and multi-cycle shift-add multiply
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
  state_t state, nxt;
  logic free, accept, is_mul, ci, c, v, vadd, vsub, hi;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] r, res1, mplier;
  logic [3:0] flg1;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [CW-1:0] cnt;
  assign free     = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && free;
  assign accept   = in_valid && in_ready;
  assign is_mul   = operation == 4'hC;
  assign hi       = |acc[2*WIDTH-1:WIDTH];
  always_comb begin
    ci   = (operation == 4'h7 || operation == 4'h8) ? cin : 1'b0;
    sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
    dif  = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(ci);
    vadd = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    vsub = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (operation)
      4'h1, 4'h7:       begin r = sum[WIDTH-1:0]; c = sum[WIDTH]; v = vadd; end
      4'h2, 4'h8, 4'hD: begin r = dif[WIDTH-1:0]; c = dif[WIDTH]; v = vsub; end
      4'h3: r = a | b;
      4'h4: r = a & b;
      4'h5: r = a ^ b;
      4'h6: r = ~a;
      4'h9: begin r = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
      4'hA: begin r = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
      4'hB: begin r = {a[WIDTH-2:0], a[WIDTH-1]}; c = a[WIDTH-1]; end
      default: r = '0;
    endcase
    // CMP reports the flags of a-b but passes a through as the result
    flg1 = (operation == 4'h0 || operation > 4'hD) ? 4'b0000 : {r[WIDTH-1], ~|r, c, v};
    res1 = (operation == 4'hD) ? a : r;
  end
  always_comb
    nxt = (state == IDLE)     ? ((accept && is_mul) ? MUL_BUSY : IDLE) :
          (state == MUL_BUSY) ? ((cnt == CW'(1)) ? DONE : MUL_BUSY) :
          free ? IDLE : DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (accept && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (state == MUL_BUSY) begin
        acc    <= mplier[0] ? acc + mcand : acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
      if (accept && !is_mul) begin
        result    <= res1;
        flags     <= flg1;
        out_valid <= 1'b1;
      end else if (state == DONE && free) begin
        result    <= acc[WIDTH-1:0];
        flags     <= {acc[WIDTH-1], ~|acc[WIDTH-1:0], hi, hi};
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule
